// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for an N-input combinational gate: drives every
// input vector, waits a settle time, and compares the gate against a reference.
module gate_sweep_ctrl #(
  parameter int unsigned N      = 2,
  parameter int unsigned SETTLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         dut_y,
  input  logic         ref_y,
  output logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic [N-1:0] first_err_vec,
  output logic         first_err_valid
);

  localparam int unsigned WW = $clog2(SETTLE) + 1;
  localparam int unsigned EW = N + 1;
  localparam logic [WW-1:0] W_LAST   = WW'(SETTLE - 1);
  localparam logic [N-1:0]  VEC_LAST = '1;
  localparam logic [EW-1:0] ERR_MAX  = EW'(1 << N);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_vec;
  logic [WW-1:0] r_wcnt;
  logic [EW-1:0] r_err_cnt;
  logic [N-1:0]  r_fev;
  logic          r_fev_vld;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;

  state_t        w_state_nxt;
  logic [N-1:0]  w_vec_nxt;
  logic [WW-1:0] w_wcnt_nxt;
  logic [EW-1:0] w_err_nxt;
  logic [EW-1:0] w_err_upd;
  logic [N-1:0]  w_fev_nxt;
  logic          w_fev_vld_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_pass_nxt;
  logic          w_mismatch;

  assign w_mismatch = dut_y ^ ref_y;

  // State and all outputs are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_vec     <= '0;
      r_wcnt    <= '0;
      r_err_cnt <= '0;
      r_fev     <= '0;
      r_fev_vld <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vec     <= w_vec_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_err_cnt <= w_err_nxt;
      r_fev     <= w_fev_nxt;
      r_fev_vld <= w_fev_vld_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
    end
  end

  // Abort overrides everything; start is only honoured when no sweep is running.
  always_comb begin
    w_state_nxt   = r_state;
    w_vec_nxt     = r_vec;
    w_wcnt_nxt    = r_wcnt;
    w_err_nxt     = r_err_cnt;
    w_err_upd     = r_err_cnt;
    w_fev_nxt     = r_fev;
    w_fev_vld_nxt = r_fev_vld;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    w_pass_nxt    = r_pass;

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_vec_nxt   = '0;
      w_wcnt_nxt  = '0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_pass_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_state_nxt   = S_WAIT;
            w_vec_nxt     = '0;
            w_wcnt_nxt    = '0;
            w_err_nxt     = '0;
            w_fev_nxt     = '0;
            w_fev_vld_nxt = 1'b0;
            w_busy_nxt    = 1'b1;
            w_done_nxt    = 1'b0;
            w_pass_nxt    = 1'b0;
          end
        end
        S_WAIT: begin
          w_wcnt_nxt = r_wcnt + WW'(1);
          if (r_wcnt == W_LAST) begin
            w_state_nxt = S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (w_mismatch) begin
            if (r_err_cnt != ERR_MAX) begin
              w_err_upd = r_err_cnt + EW'(1);
            end
            if (!r_fev_vld) begin
              w_fev_nxt     = r_vec;
              w_fev_vld_nxt = 1'b1;
            end
          end
          w_err_nxt = w_err_upd;
          if (r_vec == VEC_LAST) begin
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_err_upd == '0);
          end else begin
            w_state_nxt = S_WAIT;
            w_vec_nxt   = r_vec + N'(1);
            w_wcnt_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign vec             = r_vec;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_cnt         = r_err_cnt;
  assign first_err_vec   = r_fev;
  assign first_err_valid = r_fev_vld;

endmodule
